// File: rtl/lcd_bus_receiver.sv
// -----------------------------------------------------------------------------
// lcd_bus_receiver
//
// Display-side end of the 8-bit 8080-style write bus. Decodes command bytes,
// CASET/RASET window parameters and the RGB565 RAMWR pixel stream, and emits
// one pixel per two-byte transfer together with its column/row coordinate.
// Optionally generates the tear-effect pulse returned to the driver.
//
// Optional feature macro: LCD_RX_FMARK_GEN_EN
//   defined   -> free-running tear counter drives lcd_fmark
//   undefined -> lcd_fmark tied low, no counter built
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous reset, active low
//   lcd_data   in   [7:0] bus data (asynchronous to clk)
//   lcd_rs     in   0 = command byte, 1 = data/parameter byte
//   lcd_wr     in   write strobe, transfer captured on its rising edge
//   lcd_fmark  out  tear-effect pulse
//   cmd_valid  out  1-cycle pulse, command byte received
//   cmd_byte   out  [7:0] last command byte
//   px_valid   out  1-cycle pulse, pixel complete
//   px_data    out  [15:0] pixel {first byte, second byte}
//   px_x       out  [8:0] column of px_data
//   px_y       out  [7:0] row of px_data
//   frame_done out  1-cycle pulse with the last pixel of the window
// -----------------------------------------------------------------------------
module lcd_bus_receiver #(
   parameter int SYNC_STAGES  = 2,
   parameter int WIDTH        = 320,
   parameter int HEIGHT       = 240,
   parameter int FMARK_PERIOD = 200000,
   parameter int FMARK_WIDTH  = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  lcd_data,
   input  logic        lcd_rs,
   input  logic        lcd_wr,
   output logic        lcd_fmark,
   output logic        cmd_valid,
   output logic [7:0]  cmd_byte,
   output logic        px_valid,
   output logic [15:0] px_data,
   output logic [8:0]  px_x,
   output logic [7:0]  px_y,
   output logic        frame_done
);

   typedef enum logic [1:0] {IDLE, CASET, RASET, RAMWR} state_t;

   // The bus idles with lcd_wr high, so the synchroniser resets to "wr high"
   // to avoid seeing a false rising edge as soon as reset is released.
   localparam logic [9:0] SYNC_IDLE = 10'h200;

   state_t      r_state;
   state_t      w_nextState;

   logic [9:0]  r_sync [SYNC_STAGES];
   logic        r_wrPrev;
   logic        w_wr;
   logic        w_rs;
   logic [7:0]  w_data;
   logic        w_strobe;
   logic        w_cmd;
   logic        w_param;

   logic [1:0]  r_parCnt;
   logic        r_startHi0;
   logic [7:0]  r_startLo;
   logic        r_endHi0;
   logic [8:0]  w_colStart;
   logic [8:0]  w_colEndRaw;
   logic [8:0]  w_colEnd;
   logic [7:0]  w_rowEnd;

   logic [8:0]  r_xs;
   logic [8:0]  r_xe;
   logic [7:0]  r_ys;
   logic [7:0]  r_ye;
   logic [8:0]  r_x;
   logic [7:0]  r_y;
   logic        r_phase;
   logic [7:0]  r_hi;
   logic        w_lastCol;
   logic        w_lastRow;

   // wr, rs and data travel through the synchroniser as one vector so that
   // rs/data are always sampled from the same stage as the strobe edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SYNC_IDLE;
         r_wrPrev <= 1'b1;
      end else begin
         r_sync[0] <= {lcd_wr, lcd_rs, lcd_data};
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_wrPrev <= w_wr;
      end
   end

   assign w_wr     = r_sync[SYNC_STAGES-1][9];
   assign w_rs     = r_sync[SYNC_STAGES-1][8];
   assign w_data   = r_sync[SYNC_STAGES-1][7:0];
   assign w_strobe = w_wr & ~r_wrPrev;
   assign w_cmd    = w_strobe & ~w_rs;
   assign w_param  = w_strobe & w_rs;

   // Window values are assembled when the 4th parameter byte is on the bus;
   // an end below the start collapses the window to a single line.
   assign w_colStart  = {r_startHi0, r_startLo};
   assign w_colEndRaw = {r_endHi0, w_data};
   assign w_colEnd    = (w_colEndRaw < w_colStart) ? w_colStart : w_colEndRaw;
   assign w_rowEnd    = (w_data < r_startLo) ? r_startLo : w_data;
   assign w_lastCol   = (r_x == r_xe);
   assign w_lastRow   = (r_y == r_ye);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_nextState;
   end

   // Next-state logic: any command byte redirects the FSM regardless of the
   // current state; a window command returns to IDLE after its 4th byte.
   always_comb begin
      w_nextState = r_state;
      if (w_cmd) begin
         case (w_data)
            8'h2A:   w_nextState = CASET;
            8'h2B:   w_nextState = RASET;
            8'h2C:   w_nextState = RAMWR;
            default: w_nextState = IDLE;
         endcase
      end else if (w_param && (r_state == CASET || r_state == RASET) &&
                   r_parCnt == 2'd3) begin
         w_nextState = IDLE;
      end
   end

   // Datapath: command capture, window parameter collection and the pixel
   // stream. A command clears the parameter counter and byte phase, which is
   // what discards half-finished parameter lists and dangling pixel bytes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_valid  <= 1'b0;
         cmd_byte   <= 8'h00;
         px_valid   <= 1'b0;
         px_data    <= 16'h0000;
         px_x       <= 9'd0;
         px_y       <= 8'd0;
         frame_done <= 1'b0;
         r_parCnt   <= 2'd0;
         r_startHi0 <= 1'b0;
         r_startLo  <= 8'h00;
         r_endHi0   <= 1'b0;
         r_xs       <= 9'd0;
         r_xe       <= 9'(WIDTH - 1);
         r_ys       <= 8'd0;
         r_ye       <= 8'(HEIGHT - 1);
         r_x        <= 9'd0;
         r_y        <= 8'd0;
         r_phase    <= 1'b0;
         r_hi       <= 8'h00;
      end else begin
         cmd_valid  <= 1'b0;
         px_valid   <= 1'b0;
         frame_done <= 1'b0;
         if (w_cmd) begin
            cmd_valid <= 1'b1;
            cmd_byte  <= w_data;
            r_parCnt  <= 2'd0;
            r_phase   <= 1'b0;
            r_x       <= r_xs;
            r_y       <= r_ys;
         end else if (w_param) begin
            case (r_state)
               CASET, RASET: begin
                  r_parCnt <= r_parCnt + 2'd1;
                  case (r_parCnt)
                     2'd0: r_startHi0 <= w_data[0];
                     2'd1: r_startLo  <= w_data;
                     2'd2: r_endHi0   <= w_data[0];
                     default: begin
                        if (r_state == CASET) begin
                           r_xs <= w_colStart;
                           r_xe <= w_colEnd;
                        end else begin
                           r_ys <= r_startLo;
                           r_ye <= w_rowEnd;
                        end
                     end
                  endcase
               end
               RAMWR: begin
                  r_phase <= ~r_phase;
                  if (!r_phase) begin
                     r_hi <= w_data;
                  end else begin
                     px_valid   <= 1'b1;
                     px_data    <= {r_hi, w_data};
                     px_x       <= r_x;
                     px_y       <= r_y;
                     frame_done <= w_lastCol & w_lastRow;
                     if (w_lastCol) begin
                        r_x <= r_xs;
                        r_y <= w_lastRow ? r_ys : r_y + 8'd1;
                     end else begin
                        r_x <= r_x + 9'd1;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   // The period parameters are referenced in both builds so an override is
   // accepted cleanly whether or not the tear generator exists.
   localparam bit FMARK_CFG_OK = (FMARK_PERIOD > 0) && (FMARK_WIDTH < FMARK_PERIOD);

`ifdef LCD_RX_FMARK_GEN_EN
   localparam int CNT_W = (FMARK_PERIOD > 1) ? $clog2(FMARK_PERIOD) : 1;

   logic [CNT_W-1:0] r_fmarkCnt;

   // Free-running tear counter; it resets to 0 so the pulse is high from the
   // first cycle after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                        r_fmarkCnt <= '0;
      else if (r_fmarkCnt == CNT_W'(FMARK_PERIOD - 1))   r_fmarkCnt <= '0;
      else                                               r_fmarkCnt <= r_fmarkCnt + 1'b1;
   end

   assign lcd_fmark = FMARK_CFG_OK && (r_fmarkCnt < CNT_W'(FMARK_WIDTH));
`else
   assign lcd_fmark = 1'b0 && FMARK_CFG_OK;
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_receiver
//
// Self-checking bench for lcd_bus_receiver. Bus writes are driven by tasks;
// each expected pixel/command is pushed to a queue before the completing byte
// is driven, and a monitor pops and compares whenever the DUT pulses.
// -----------------------------------------------------------------------------
module tb_lcd_bus_receiver;

   typedef struct {
      logic [15:0] d;
      logic [8:0]  x;
      logic [7:0]  y;
      logic        fd;
   } pix_t;

   logic        clk;
   logic        rst_n;
   logic [7:0]  lcd_data;
   logic        lcd_rs;
   logic        lcd_wr;
   logic        lcd_fmark;
   logic        cmd_valid;
   logic [7:0]  cmd_byte;
   logic        px_valid;
   logic [15:0] px_data;
   logic [8:0]  px_x;
   logic [7:0]  px_y;
   logic        frame_done;

   pix_t        expPx[$];
   logic [7:0]  expCmd[$];
   pix_t        gotPx;
   logic [7:0]  gotCmd;

   int          checkCount = 0;
   int          passCount  = 0;

   lcd_bus_receiver #(
      .SYNC_STAGES (2),
      .WIDTH       (320),
      .HEIGHT      (240),
      .FMARK_PERIOD(100),
      .FMARK_WIDTH (10)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .lcd_data  (lcd_data),
      .lcd_rs    (lcd_rs),
      .lcd_wr    (lcd_wr),
      .lcd_fmark (lcd_fmark),
      .cmd_valid (cmd_valid),
      .cmd_byte  (cmd_byte),
      .px_valid  (px_valid),
      .px_data   (px_data),
      .px_x      (px_x),
      .px_y      (px_y),
      .frame_done(frame_done)
   );

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp)
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      else
         passCount++;
   endtask

   // One bus transfer: wr low for 3 cycles then high for 3 cycles, with rs and
   // data held stable across the rising edge.
   task automatic applyStimulus(input logic rs, input logic [7:0] d);
      @(negedge clk);
      lcd_rs   = rs;
      lcd_data = d;
      lcd_wr   = 1'b0;
      repeat (3) @(negedge clk);
      lcd_wr   = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic sendCmd(input logic [7:0] c);
      expCmd.push_back(c);
      applyStimulus(1'b0, c);
   endtask

   task automatic sendParams(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
      applyStimulus(1'b1, a);
      applyStimulus(1'b1, b);
      applyStimulus(1'b1, c);
      applyStimulus(1'b1, d);
   endtask

   task automatic sendPixel(input logic [15:0] d, input int x, input int y, input logic fd);
      pix_t e;
      e.d  = d;
      e.x  = 9'(x);
      e.y  = 8'(y);
      e.fd = fd;
      expPx.push_back(e);
      applyStimulus(1'b1, d[15:8]);
      applyStimulus(1'b1, d[7:0]);
   endtask

   // Wait (bounded) until every expected pulse has been seen, then idle a few
   // cycles so stray pulses are caught by the monitor.
   task automatic waitDrain(input string tag);
      int n = 0;
      while ((expPx.size() + expCmd.size()) != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 32'(expPx.size() + expCmd.size()), 32'd0);
      repeat (8) @(negedge clk);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
      checkOutput({tag, "_cmd_byte"},  32'(cmd_byte),  32'd0);
      checkOutput({tag, "_px_valid"},  32'(px_valid),  32'd0);
      checkOutput({tag, "_px_data"},   32'(px_data),   32'd0);
      checkOutput({tag, "_px_x"},      32'(px_x),      32'd0);
      checkOutput({tag, "_px_y"},      32'(px_y),      32'd0);
      checkOutput({tag, "_frame_done"},32'(frame_done),32'd0);
`ifndef LCD_RX_FMARK_GEN_EN
      checkOutput({tag, "_fmark"},     32'(lcd_fmark), 32'd0);
`endif
   endtask

   task automatic resetDut(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkResetOutputs(tag);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Monitor: every output pulse must match the head of its queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (px_valid) begin
            if (expPx.size() == 0) begin
               checkOutput("px_unexpected", 32'(expPx.size()), 32'd1);
            end else begin
               gotPx = expPx.pop_front();
               checkOutput("px_data", 32'(px_data),    32'(gotPx.d));
               checkOutput("px_x",    32'(px_x),       32'(gotPx.x));
               checkOutput("px_y",    32'(px_y),       32'(gotPx.y));
               checkOutput("px_fd",   32'(frame_done), 32'(gotPx.fd));
            end
         end else if (frame_done) begin
            checkOutput("fd_without_px", 32'(frame_done), 32'(px_valid));
         end
         if (cmd_valid) begin
            if (expCmd.size() == 0) begin
               checkOutput("cmd_unexpected", 32'(expCmd.size()), 32'd1);
            end else begin
               gotCmd = expCmd.pop_front();
               checkOutput("cmd_byte", 32'(cmd_byte), 32'(gotCmd));
            end
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      lcd_wr   = 1'b1;
      lcd_rs   = 1'b1;
      lcd_data = 8'h00;
      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      rst_n = 1'b1;

      // Tear pulse: high for 10 of every 100 cycles from release, or never.
`ifdef LCD_RX_FMARK_GEN_EN
      for (int k = 0; k < 120; k++) begin
         checkOutput("fmark", 32'(lcd_fmark), 32'((k % 100) < 10));
         @(negedge clk);
      end
`else
      for (int k = 0; k < 20; k++) begin
         if (k % 5 == 0) checkOutput("fmark_off", 32'(lcd_fmark), 32'd0);
         @(negedge clk);
      end
`endif

      // Test 1: default window, two pixels.
      sendCmd(8'h2C);
      sendPixel(16'hF800, 0, 0, 1'b0);
      sendPixel(16'h07E0, 1, 0, 1'b0);
      waitDrain("t1_drain");

      // Test 2: 3x2 window, frame_done on 6th, 7th wraps to origin.
      sendCmd(8'h2A);
      sendParams(8'h00, 8'h0A, 8'h00, 8'h0C);
      sendCmd(8'h2B);
      sendParams(8'h00, 8'h05, 8'h00, 8'h06);
      sendCmd(8'h2C);
      begin
         int xs[7] = '{10, 11, 12, 10, 11, 12, 10};
         int ys[7] = '{5, 5, 5, 6, 6, 6, 5};
         for (int i = 0; i < 7; i++)
            sendPixel(16'h1000 + 16'(i * 16'h0111), xs[i], ys[i], i == 5);
      end
      waitDrain("t2_drain");

      // Test 3: aborted CASET leaves the default window; then end < start.
      resetDut("t3_reset");
      sendCmd(8'h2A);
      applyStimulus(1'b1, 8'h00);
      applyStimulus(1'b1, 8'h0A);
      sendCmd(8'h2C);
      sendPixel(16'hA5A5, 0, 0, 1'b0);
      sendCmd(8'h2A);
      sendParams(8'h00, 8'h20, 8'h00, 8'h10);
      sendCmd(8'h2C);
      sendPixel(16'h1234, 32, 0, 1'b0);
      sendPixel(16'h5678, 32, 1, 1'b0);
      waitDrain("t3_drain");

      // Test 4: dangling byte discarded by a non-window command.
      sendCmd(8'h2C);
      sendPixel(16'hBEEF, 32, 0, 1'b0);
      applyStimulus(1'b1, 8'h77);
      sendCmd(8'h00);
      applyStimulus(1'b1, 8'h11);
      applyStimulus(1'b1, 8'h22);
      waitDrain("t4_drain");

      // Test 5: reset between the two bytes of a pixel.
      sendCmd(8'h2C);
      applyStimulus(1'b1, 8'hF8);
      waitDrain("t5_pre");
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkResetOutputs("t5_reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      applyStimulus(1'b1, 8'h1F);
      sendCmd(8'h2C);
      sendPixel(16'hABCD, 0, 0, 1'b0);
      waitDrain("t5_drain");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
